traffic_light_monitor: RTL
==========================

# traffic_light_monitor

Passive checker on the receiving end of the intersection light bus. It samples the `red`/`yellow`/`green` lines every clock and decodes the current phase. It measures how long each phase dwells and checks the RED→GREEN→YELLOW→RED order and the per-phase durations. Violations are reported as single-cycle pulses and sticky status bits, and every error-free full cycle is counted; it sits beside the light controller in simulation and on-chip self-test.

## Interface
- `RED_CYCLES`, default 11: required RED dwell, in samples.
- `GREEN_CYCLES`, default 9: required GREEN dwell, in samples.
- `YELLOW_CYCLES`, default 3: required YELLOW dwell, in samples.
- `CNT_W`, default 8: dwell counter width. Every `*_CYCLES` value is less than 2^CNT_W−1.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `red`, `yellow`, `green` in 1 each: light lines under observation, synchronous to `clk`.
- `clear_err` in 1: one-cycle pulse that clears `err_status`.
- `phase` out 2: decoded phase. 00 RED, 01 GREEN, 10 YELLOW, 11 ACQUIRE.
- `locked` out 1: high while tracking a phase, i.e. `phase` is not ACQUIRE.
- `dwell` out CNT_W: number of consecutive samples in the current phase, saturating at all-ones.
- `err_illegal` out 1: pulse, light encoding is not one-hot.
- `err_order` out 1: pulse, wrong successor phase.
- `err_duration` out 1: pulse, phase too short or too long.
- `err_status` out 3: sticky bits {duration, order, illegal}.
- `cycle_count` out 16: number of error-free complete cycles; wraps.

## Operation
- **Per-edge decode.** Each rising edge samples the three lines. A sample is legal only when exactly one line is high.
- **Illegal sample.**
  - Pulse `err_illegal`.
  - Go to ACQUIRE, set `dwell`=0, set the cycle-dirty flag.
  - No order or duration check is made on that edge.
- **ACQUIRE.**
  - Non-red legal samples are ignored. They raise no errors.
  - A red-only sample enters RED with `dwell`=1 and clears the cycle-dirty flag.
- **Tracked phase, same light as the current phase.**
  - `dwell` increments, saturating.
  - When `dwell` becomes expected+1, pulse `err_duration` and set dirty. This happens at most once per phase.
- **Tracked phase, different legal light.**
  - Check duration: if `dwell` < expected for the phase being left, pulse `err_duration` and set dirty.
  - Check order: the successor must be RED→GREEN, GREEN→YELLOW or YELLOW→RED. Any other successor pulses `err_order`, sets dirty, and resyncs to the observed phase.
  - In every case the new phase starts with `dwell`=1.
- **Cycle completion.**
  - On a YELLOW→RED transition with no error on that edge and dirty=0, increment `cycle_count` (modulo 2^16).
  - Every entry into RED clears dirty after this evaluation.
- **Duration and order on the same edge.** Both errors can pulse together.
- **Sticky status.**
  - Each pulse sets its `err_status` bit.
  - `clear_err` zeroes the bits.
  - If a set and a clear land on the same edge, the set wins for that bit.
- **Reset.** Asynchronous, and effective mid-phase.
  - `phase`=11, `locked`=0, `dwell`=0.
  - All pulses 0, `err_status`=0, `cycle_count`=0, dirty=0.

## Timing
- All outputs are registered. The response to the sample taken at edge k appears immediately after edge k and is held until edge k+1. There is no additional pipeline latency.
- Error pulses are exactly one cycle wide.
- `dwell` saturates at 2^CNT_W−1. The long-duration pulse has already fired well before saturation.
- The first legal red sample after reset is treated as the start of a full RED phase.

## Test plan
- **Nominal cycle.** Release reset, then drive 11 red, 9 green, 3 yellow, 11 red samples (default parameters).
  - `phase` goes 00→01→10→00.
  - `cycle_count`=1 immediately after the first red sample that follows yellow.
  - All error outputs stay 0.
- **Short green.** Drive 11 red, 8 green, then yellow.
  - `err_duration` pulses on the first yellow edge.
  - `err_status`=3'b100.
  - The following yellow→red transition does not increment `cycle_count`.
- **Long red.** Hold red for 14 samples.
  - `err_duration` pulses once, on the 12th red sample.
  - No further duration pulse, including at the later red→green change.
- **Order error.** Drive 11 red, then yellow.
  - `err_order` pulses.
  - `phase`=10 and `dwell`=1.
- **Illegal encoding.** Drive red and green together for one sample.
  - `err_illegal` pulses.
  - `phase`=11, `locked`=0, `err_status[0]`=1.
  - The next red-only sample relocks with `dwell`=1.
- **Clear and reset.**
  - Assert `clear_err` on the same edge as an `err_order`: `err_status[1]` stays 1.
  - Assert `clear_err` alone on the next edge: `err_status`=0.
  - Assert `reset` mid-GREEN: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//
// Passive checker for the intersection light bus. Every rising edge of clk
// samples the red/yellow/green lines, decodes the current phase, measures how
// long the phase has dwelt and checks both the RED->GREEN->YELLOW->RED order
// and the per-phase dwell lengths. Errors are reported as one-cycle pulses plus
// sticky status bits. Every complete cycle that has no error is counted.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   red, yellow, green   observed light lines, synchronous to clk
//   clear_err            one-cycle pulse that zeroes err_status
//   phase[1:0]           00 RED, 01 GREEN, 10 YELLOW, 11 ACQUIRE
//                        (this is the FSM state, exposed directly)
//   locked               high while phase != ACQUIRE
//   dwell[CNT_W-1:0]     consecutive samples in the current phase, saturating
//   err_illegal          pulse: the sample is not one-hot
//   err_order            pulse: wrong successor phase
//   err_duration         pulse: phase too short or too long
//   err_status[2:0]      sticky {duration, order, illegal}
//   cycle_count[15:0]    error-free complete cycles, wraps
//
// All outputs are registered: the response to the sample taken at edge k is
// visible right after edge k and holds until edge k+1.
module traffic_light_monitor #(
  parameter int RED_CYCLES    = 11,
  parameter int GREEN_CYCLES  = 9,
  parameter int YELLOW_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic             locked,
  output logic [CNT_W-1:0] dwell,
  output logic             err_illegal,
  output logic             err_order,
  output logic             err_duration,
  output logic [2:0]       err_status,
  output logic [15:0]      cycle_count
);

  typedef enum logic [1:0] {
    PH_RED    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_ACQ    = 2'b11
  } phase_t;

  localparam logic [CNT_W-1:0] EXP_RED    = CNT_W'(RED_CYCLES);
  localparam logic [CNT_W-1:0] EXP_GREEN  = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] EXP_YELLOW = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  // State and registered outputs
  phase_t           r_phase;
  logic [CNT_W-1:0] r_dwell;
  logic             r_dirty;
  logic             r_locked;
  logic             r_err_ill;
  logic             r_err_ord;
  logic             r_err_dur;
  logic [2:0]       r_err_status;
  logic [15:0]      r_cycle_count;

  // Next-state values
  phase_t           w_phase_nxt;
  logic [CNT_W-1:0] w_dwell_nxt;
  logic             w_dirty_nxt;
  logic             w_ill;
  logic             w_ord;
  logic             w_dur;
  logic             w_cycle_done;
  logic             w_legal;
  phase_t           w_obs;
  logic [CNT_W-1:0] w_exp;
  logic [CNT_W-1:0] w_dwell_inc;

  function automatic logic [CNT_W-1:0] exp_of(input phase_t p);
    case (p)
      PH_RED:    exp_of = EXP_RED;
      PH_GREEN:  exp_of = EXP_GREEN;
      PH_YELLOW: exp_of = EXP_YELLOW;
      default:   exp_of = '0;
    endcase
  endfunction

  function automatic phase_t succ_of(input phase_t p);
    case (p)
      PH_RED:    succ_of = PH_GREEN;
      PH_GREEN:  succ_of = PH_YELLOW;
      PH_YELLOW: succ_of = PH_RED;
      default:   succ_of = PH_RED;
    endcase
  endfunction

  always_comb begin
    w_phase_nxt  = r_phase;
    w_dwell_nxt  = r_dwell;
    w_dirty_nxt  = r_dirty;
    w_ill        = 1'b0;
    w_ord        = 1'b0;
    w_dur        = 1'b0;
    w_cycle_done = 1'b0;

    // Exactly one of three lines high: odd parity, but not all three.
    w_legal = (red ^ yellow ^ green) & ~(red & yellow & green);
    if (red)        w_obs = PH_RED;
    else if (green) w_obs = PH_GREEN;
    else            w_obs = PH_YELLOW;

    w_exp       = exp_of(r_phase);
    w_dwell_inc = (r_dwell == '1) ? r_dwell : r_dwell + ONE;

    if (!w_legal) begin
      w_ill       = 1'b1;
      w_phase_nxt = PH_ACQ;
      w_dwell_nxt = '0;
      w_dirty_nxt = 1'b1;
    end else if (r_phase == PH_ACQ) begin
      // Only a red sample can start tracking; anything else is ignored.
      if (w_obs == PH_RED) begin
        w_phase_nxt = PH_RED;
        w_dwell_nxt = ONE;
        w_dirty_nxt = 1'b0;
      end
    end else if (w_obs == r_phase) begin
      w_dwell_nxt = w_dwell_inc;
      // The dwell only passes through expected+1 once per phase, so the
      // overlong pulse fires at most once without a separate flag.
      if ((w_dwell_inc != r_dwell) && (w_dwell_inc == w_exp + ONE)) begin
        w_dur = 1'b1;
      end
      w_dirty_nxt = r_dirty | w_dur;
    end else begin
      w_dur       = (r_dwell < w_exp);
      w_ord       = (w_obs != succ_of(r_phase));
      w_phase_nxt = w_obs;   // resync to what was observed in every case
      w_dwell_nxt = ONE;
      w_cycle_done = (r_phase == PH_YELLOW) && (w_obs == PH_RED) &&
                     !w_dur && !w_ord && !r_dirty;
      // A new cycle starts at every RED entry, so errors seen on that edge
      // belong to the cycle that just ended.
      w_dirty_nxt = (w_obs == PH_RED) ? 1'b0 : (r_dirty | w_dur | w_ord);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase       <= PH_ACQ;
      r_dwell       <= '0;
      r_dirty       <= 1'b0;
      r_locked      <= 1'b0;
      r_err_ill     <= 1'b0;
      r_err_ord     <= 1'b0;
      r_err_dur     <= 1'b0;
      r_err_status  <= '0;
      r_cycle_count <= '0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_dwell      <= w_dwell_nxt;
      r_dirty      <= w_dirty_nxt;
      r_locked     <= (w_phase_nxt != PH_ACQ);
      r_err_ill    <= w_ill;
      r_err_ord    <= w_ord;
      r_err_dur    <= w_dur;
      // A set on the same edge as a clear wins for that bit.
      r_err_status <= (clear_err ? 3'b000 : r_err_status) | {w_dur, w_ord, w_ill};
      if (w_cycle_done) r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign phase        = r_phase;
  assign locked       = r_locked;
  assign dwell        = r_dwell;
  assign err_illegal  = r_err_ill;
  assign err_order    = r_err_ord;
  assign err_duration = r_err_dur;
  assign err_status   = r_err_status;
  assign cycle_count  = r_cycle_count;

endmodule
